// File: rtl/axi_wr_slave.sv
// Single-outstanding AXI write slave that turns bursts into registered word writes.
// FIXED, INCR and WRAP bursts are supported; protocol violations complete with SLVERR.
module axi_wr_slave #(
    parameter int MEM_WORDS = 256
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [3:0]                   AWID,
    input  logic [31:0]                  AWADDR,
    input  logic [3:0]                   AWLEN,
    input  logic [2:0]                   AWSIZE,
    input  logic [1:0]                   AWBURST,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [3:0]                   WID,
    input  logic [31:0]                  WDATA,
    input  logic [3:0]                   WSTRB,
    input  logic                         WLAST,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [3:0]                   BID,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic                         mem_we,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [3:0]                   mem_wstrb
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t        state_q;
    logic [3:0]    id_q, len_q, beat_q;
    logic [31:0]   addr_q;
    logic [2:0]    size_q;
    logic [1:0]    burst_q;
    logic          err_q;
    logic          awready_q, wready_q, bvalid_q;
    logic [3:0]    bid_q;
    logic [1:0]    bresp_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_wstrb_q;

    logic          aw_err, beat_err, last_beat;
    logic [31:0]   inc, wrap_mask, addr_d;

    // Errors detectable from the address phase alone
    always_comb begin
        aw_err = (AWBURST == 2'd3) || (AWSIZE > 3'd2);
        if (AWBURST == 2'd2) begin
            if (!(AWLEN inside {4'd1, 4'd3, 4'd7, 4'd15}))
                aw_err = 1'b1;
            if ((AWADDR & ((32'd1 << AWSIZE) - 32'd1)) != 32'd0)
                aw_err = 1'b1;
        end
    end

    assign last_beat = (beat_q == len_q);
    assign beat_err  = err_q || (WID != id_q) || (WLAST != last_beat) ||
                       (addr_q >= ADDR_LIMIT);

    // WRAP keeps the high bits of the block base and wraps the low bits
    always_comb begin
        inc       = 32'd1 << size_q;
        wrap_mask = (({28'd0, len_q} + 32'd1) << size_q) - 32'd1;
        case (burst_q)
            2'd1:    addr_d = addr_q + inc;
            2'd2:    addr_d = (addr_q & ~wrap_mask) | ((addr_q + inc) & wrap_mask);
            default: addr_d = addr_q;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            id_q        <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    awready_q <= 1'b1;
                    if (AWVALID && awready_q) begin
                        id_q      <= AWID;
                        addr_q    <= AWADDR;
                        len_q     <= AWLEN;
                        size_q    <= AWSIZE;
                        burst_q   <= AWBURST;
                        beat_q    <= '0;
                        err_q     <= aw_err;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (WVALID && wready_q) begin
                        if (!beat_err) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr_q[AW+1:2];
                            mem_wdata_q <= WDATA;
                            mem_wstrb_q <= WSTRB;
                        end
                        addr_q <= addr_d;
                        beat_q <= beat_q + 4'd1;
                        err_q  <= beat_err;
                        // Beat count, not WLAST, terminates the burst
                        if (last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= beat_err ? 2'b10 : 2'b00;
                            state_q  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (BREADY && bvalid_q) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BID       = bid_q;
    assign BRESP     = bresp_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed bench for axi_wr_slave: stimulus pushes expected writes/responses into
// queues, a negedge monitor pops and compares whenever the DUT presents them.
module tb_axi_wr_slave;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [3:0]  WID = '0;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    axi_wr_slave #(.MEM_WORDS(256)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { logic [7:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;
    wr_t wq[$];
    b_t  bq[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops on every mem write and on every new BVALID
    initial begin
        logic b_seen;
        wr_t w;
        b_t  b;
        b_seen = 1'b0;
        forever begin
            @(negedge ACLK);
            if (!ARESET) begin
                if (mem_we) begin
                    if (wq.size() == 0) chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                    else begin
                        w = wq.pop_front();
                        chk("wr_addr", 32'(mem_addr), 32'(w.a));
                        chk("wr_data", mem_wdata, w.d);
                        chk("wr_strb", 32'(mem_wstrb), 32'(w.s));
                    end
                end
                if (BVALID && !b_seen) begin
                    if (bq.size() == 0) chk("unexpected_b", 32'(BID), 32'hFFFF_FFFF);
                    else begin
                        b = bq.pop_front();
                        chk("bid", 32'(BID), 32'(b.id));
                        chk("bresp", 32'(BRESP), 32'(b.resp));
                    end
                end
                b_seen = BVALID;
            end else b_seen = 1'b0;
        end
    end

    // All tasks start and end at a negedge
    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) chk("aw_timeout", 32'd0, 32'd1);
        @(negedge ACLK);
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [3:0] id, input logic [31:0] d,
                          input logic [3:0] s, input logic last);
        int n = 0;
        WID = id; WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
        while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) chk("w_timeout", 32'd0, 32'd1);
        @(negedge ACLK);
        WVALID = 1'b0;
    endtask

    task automatic take_b(input int hold);
        int n = 0;
        logic [3:0] id0;
        logic [1:0] r0;
        BREADY = 1'b0;
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) chk("b_timeout", 32'd0, 32'd1);
        id0 = BID; r0 = BRESP;
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            chk("hold_bvalid", 32'(BVALID), 32'd1);
            chk("hold_bid", 32'(BID), 32'(id0));
            chk("hold_bresp", 32'(BRESP), 32'(r0));
            chk("hold_awready", 32'(AWREADY), 32'd0);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("post_b_bvalid", 32'(BVALID), 32'd0);
        chk("post_b_awready", 32'(AWREADY), 32'd1);
    endtask

    task automatic push_w(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_t w;
        w.a = a; w.d = d; w.s = s;
        wq.push_back(w);
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] r);
        b_t b;
        b.id = id; b.resp = r;
        bq.push_back(b);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, 32'(AWREADY), 32'd0);
        chk({tag, "_wready"}, 32'(WREADY), 32'd0);
        chk({tag, "_bvalid"}, 32'(BVALID), 32'd0);
        chk({tag, "_bid_bresp"}, {26'd0, BID, BRESP}, 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    endtask

    logic [3:0] strbs [3] = '{4'h1, 4'h2, 4'h4};
    logic [7:0] wrap_words [4] = '{8'd14, 8'd15, 8'd12, 8'd13};

    initial begin
        @(negedge ACLK);
        @(negedge ACLK);
        chk_reset_outputs("rst");
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("awready_after_reset", 32'(AWREADY), 32'd1);

        // INCR 0x10, LEN=3 -> words 4..7
        for (int i = 0; i < 4; i++) push_w(8'(4 + i), 32'hA000_0000 + i, 4'hF);
        push_b(4'h5, 2'b00);
        send_aw(4'h5, 32'h10, 4'd3, 3'd2, 2'd1);
        for (int i = 0; i < 4; i++) send_w(4'h5, 32'hA000_0000 + i, 4'hF, i == 3);
        take_b(0);

        // WRAP 0x38, LEN=3 -> words 14,15,12,13
        for (int i = 0; i < 4; i++) push_w(wrap_words[i], 32'hB000_0000 + i, 4'hF);
        push_b(4'h3, 2'b00);
        send_aw(4'h3, 32'h38, 4'd3, 3'd2, 2'd2);
        for (int i = 0; i < 4; i++) send_w(4'h3, 32'hB000_0000 + i, 4'hF, i == 3);
        take_b(0);

        // FIXED 0x8 bytes, three writes to word 2
        for (int i = 0; i < 3; i++) push_w(8'd2, 32'hC000_0000 + i, strbs[i]);
        push_b(4'h9, 2'b00);
        send_aw(4'h9, 32'h8, 4'd2, 3'd0, 2'd0);
        for (int i = 0; i < 3; i++) send_w(4'h9, 32'hC000_0000 + i, strbs[i], i == 2);
        take_b(0);

        // Early WLAST on beat 1: only beat 0 written, all four accepted
        push_w(8'd8, 32'hD000_0000, 4'hF);
        push_b(4'h7, 2'b10);
        send_aw(4'h7, 32'h20, 4'd3, 3'd2, 2'd1);
        for (int i = 0; i < 4; i++) send_w(4'h7, 32'hD000_0000 + i, 4'hF, i == 1);
        take_b(0);

        // LEN=0 minimum turnaround with BREADY held low for 5 cycles
        push_w(8'd1, 32'hE000_0001, 4'hC);
        push_b(4'hA, 2'b00);
        send_aw(4'hA, 32'h4, 4'd0, 3'd2, 2'd1);
        chk("wready_after_aw", 32'(WREADY), 32'd1);
        send_w(4'hA, 32'hE000_0001, 4'hC, 1'b1);
        chk("turnaround_mem_we", 32'(mem_we), 32'd1);
        chk("turnaround_bvalid", 32'(BVALID), 32'd1);
        chk("wready_drop", 32'(WREADY), 32'd0);
        take_b(5);

        // Out-of-range address: no write, SLVERR
        push_b(4'h1, 2'b10);
        send_aw(4'h1, 32'h400, 4'd0, 3'd2, 2'd1);
        send_w(4'h1, 32'h1234_5678, 4'hF, 1'b1);
        take_b(0);

        // Reserved burst type: no write, SLVERR
        push_b(4'h6, 2'b10);
        send_aw(4'h6, 32'h0, 4'd0, 3'd2, 2'd3);
        send_w(4'h6, 32'h1111_1111, 4'hF, 1'b1);
        take_b(0);

        // Reset after beat 1 of a LEN=7 burst abandons it
        push_w(8'd16, 32'hF000_0000, 4'hF);
        push_w(8'd17, 32'hF000_0001, 4'hF);
        send_aw(4'h4, 32'h40, 4'd7, 3'd2, 2'd1);
        send_w(4'h4, 32'hF000_0000, 4'hF, 1'b0);
        send_w(4'h4, 32'hF000_0001, 4'hF, 1'b0);
        @(negedge ACLK);
        ARESET = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("awready_after_mid_rst", 32'(AWREADY), 32'd1);
        chk("no_b_after_rst", 32'(BVALID), 32'd0);

        push_w(8'd0, 32'h0BAD_CAFE, 4'hF);
        push_b(4'h2, 2'b00);
        send_aw(4'h2, 32'h0, 4'd0, 3'd2, 2'd1);
        send_w(4'h2, 32'h0BAD_CAFE, 4'hF, 1'b1);
        take_b(0);

        repeat (3) @(negedge ACLK);
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("bq_drained", 32'(bq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/axi_wr_slave.md
AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

Interface
REQ-001 MEM_WORDS, 256, depth of the attached 32-bit word memory; power of two, 16..65536.
REQ-002 ACLK  in  1  sole clock; all logic samples on its rising edge.
REQ-003 ARESET  in  1  reset, asynchronous and active-high.
REQ-004 AWID in 4, AWADDR in 32, AWLEN in 4, AWSIZE in 3, AWBURST in 2, AWVALID in 1  write-address request from the master.
REQ-005 AWREADY  out  1  address accept.
REQ-006 WID in 4, WDATA in 32, WSTRB in 4, WLAST in 1, WVALID in 1  write-data beat.
REQ-007 WREADY  out  1  data accept.
REQ-008 BID out 4, BRESP out 2, BVALID out 1  write response.
REQ-009 BREADY  in  1  response accept.
REQ-010 mem_we out 1, mem_addr out log2(MEM_WORDS), mem_wdata out 32, mem_wstrb out 4  registered word-write port to the memory.

Function
REQ-011 The FSM SHALL have three states: IDLE, DATA, RESP; one transaction in flight; no outstanding-address queue.
REQ-012 In IDLE, AWREADY=1, WREADY=0 and BVALID=0; an AW handshake latches ID, ADDR, LEN, SIZE, BURST, clears beat count and error flag, and moves to DATA.
REQ-013 In DATA, AWREADY=0 and WREADY=1; each W handshake is one beat; WREADY rises the cycle after the AW handshake.
REQ-014 Each accepted beat with no error SHALL drive mem_we=1 the next cycle, with mem_addr=cur_addr[log2(MEM_WORDS)+1:2], mem_wdata=WDATA and mem_wstrb=WSTRB; otherwise mem_we=0.
REQ-015 The next address SHALL be: FIXED (0) unchanged; INCR (1) cur+(1<<SIZE); WRAP (2) cur+(1<<SIZE) wrapped within a block of (LEN+1)<<SIZE bytes aligned to that size.
REQ-016 Address arithmetic SHALL be 32-bit modulo 2^32; INCR does not enforce the 4 KB boundary.
REQ-017 The error flag SHALL set, and stay set until the response, if any of these occur:
- BURST=3;
- SIZE>2;
- WRAP with LEN not in {1,3,7,15} or ADDR not aligned to 1<<SIZE;
- WID differs from the latched ID;
- WLAST=1 on a beat other than beat LEN;
- WLAST=0 on beat LEN;
- any beat address >= 4*MEM_WORDS.
REQ-018 Once the error flag is set, all remaining beats of the burst are still accepted but SHALL NOT write memory.
REQ-019 The burst SHALL end on the W handshake of beat LEN, regardless of WLAST; the FSM moves to RESP and WREADY drops the next cycle.
REQ-020 In RESP, BVALID=1 with BID=latched ID and BRESP=2'b10 (SLVERR) if the error flag is set, else 2'b00 (OKAY).
REQ-021 BID and BRESP SHALL be held stable while BVALID=1 and BREADY=0; on the B handshake the FSM returns to IDLE.
REQ-022 The earliest next AWREADY SHALL be the cycle after the B handshake; AW and B never overlap.
REQ-023 Minimum turnaround for a LEN=0 write SHALL be: AW handshake at T, W at T+1, mem_we at T+2, BVALID at T+2.
REQ-024 All outputs SHALL be registered; VALID/READY are never combinationally dependent on the peer's VALID/READY.

Reset
REQ-025 ARESET=1 SHALL immediately force: state IDLE, AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, beat count 0, error flag 0.
REQ-026 AWREADY SHALL rise on the first ACLK edge after ARESET deasserts.
REQ-027 Reset mid-burst SHALL abandon the transaction: no B response is issued and no further memory writes occur.

Verification
REQ-028 INCR, AWADDR=0x10, LEN=3, SIZE=2, WSTRB=0xF -> mem_we on 4 cycles at word addresses 4,5,6,7; then BRESP=OKAY, BID=AWID.
REQ-029 WRAP, AWADDR=0x38, LEN=3, SIZE=2 -> word addresses 14,15,12,13; BRESP=OKAY.
REQ-030 FIXED, AWADDR=0x8, LEN=2, SIZE=0, WSTRB=0x1,0x2,0x4 -> three writes to word 2 with those strobes.
REQ-031 INCR, LEN=3 with WLAST asserted on beat 1 -> beat 0 written only; all 4 beats accepted; BRESP=SLVERR.
REQ-032 BREADY held low 5 cycles in RESP -> BVALID, BID, BRESP stable; AWREADY stays 0 until the cycle after the handshake.
REQ-033 ARESET pulsed after beat 1 of a LEN=7 INCR burst -> outputs at reset values, no BVALID; a following LEN=0 write completes with OKAY.
